// File: rtl/beam_trigger_aligner.sv
// Per-beam delay-and-sum power trigger across 8 ADC channels, 8 samples per clock.
// Each beam delays every channel by (b*k) mod 16 samples, sums the aligned channels,
// squares and accumulates over the clock's 8 samples, and compares against a
// double-buffered threshold. Fixed 4-cycle latency after capture.
module beam_trigger_aligner #(
  parameter int unsigned NBEAMS = 46
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [39:0]       data_i [7:0],
  input  logic [17:0]       thresh_i,
  input  logic [NBEAMS-1:0] thresh_ce_i,
  input  logic              update_i,
  output logic [NBEAMS-1:0] trigger_o
);

  // Sum of eight signed 5-bit taps; the true range (-128..120) fits 8 bits exactly.
  function automatic logic [7:0] add8(input logic [39:0] t);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc = acc + {{3{t[5*k+4]}}, t[5*k +: 5]};
    end
    return acc;
  endfunction

  // Square of a signed 8-bit value; |v| <= 128 so the result fits 15 bits.
  function automatic logic [14:0] square15(input logic [7:0] v);
    logic [7:0]  mag;
    logic [14:0] p;
    mag = v[7] ? (~v + 8'd1) : v;
    p   = 15'(mag) * 15'(mag);
    return p;
  endfunction

  // hist0 is the clock just captured, hist2 the oldest of the three.
  logic [39:0]  hist0_q [8];
  logic [39:0]  hist1_q [8];
  logic [39:0]  hist2_q [8];
  logic [119:0] win [8];

  logic [17:0]       pend_q [NBEAMS];
  logic [17:0]       act_q  [NBEAMS];
  logic [NBEAMS-1:0] trig_d;
  logic [NBEAMS-1:0] trig_q;

  // Shift the three-clock sample history for each channel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 8; k++) begin
        hist0_q[k] <= '0;
        hist1_q[k] <= '0;
        hist2_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        hist0_q[k] <= data_i[k];
        hist1_q[k] <= hist0_q[k];
        hist2_q[k] <= hist1_q[k];
      end
    end
  end

  // 24-sample window per channel, oldest sample at bit 0; current clock's sample s is at 16+s.
  for (genvar k = 0; k < 8; k++) begin : g_win
    assign win[k] = {hist0_q[k], hist1_q[k], hist2_q[k]};
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    logic [7:0]  sum_d [8];
    logic [7:0]  sum_q [8];
    logic [14:0] sq_d  [8];
    logic [14:0] sq_q  [8];
    logic [17:0] pwr_d;
    logic [17:0] pwr_q;

    for (genvar s = 0; s < 8; s++) begin : g_samp
      logic [39:0] taps;
      for (genvar k = 0; k < 8; k++) begin : g_ch
        localparam int unsigned Idx = 16 + s - ((b * k) % 16);
        assign taps[5*k +: 5] = win[k][5*Idx +: 5];
      end
      assign sum_d[s] = add8(taps);
      assign sq_d[s]  = square15(sum_q[s]);
    end

    // Accumulate the eight squared beam samples of one clock.
    always_comb begin
      pwr_d = '0;
      for (int s = 0; s < 8; s++) begin
        pwr_d = pwr_d + 18'(sq_q[s]);
      end
    end

    // Beam pipeline: sums, squares, power.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s < 8; s++) begin
          sum_q[s] <= '0;
          sq_q[s]  <= '0;
        end
        pwr_q <= '0;
      end else begin
        for (int s = 0; s < 8; s++) begin
          sum_q[s] <= sum_d[s];
          sq_q[s]  <= sq_d[s];
        end
        pwr_q <= pwr_d;
      end
    end

    // Strict compare: power equal to the threshold does not trigger.
    assign trig_d[b] = (pwr_q > act_q[b]);
  end

  // Double-buffered thresholds; update copies pending values from before this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        pend_q[b] <= '1;
        act_q[b]  <= '1;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (update_i) begin
          act_q[b] <= pend_q[b];
        end
        if (thresh_ce_i[b]) begin
          pend_q[b] <= thresh_i;
        end
      end
    end
  end

  // Register the per-beam trigger bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign trigger_o = trig_q;

endmodule

// File: tb/tb_beam_trigger_aligner.sv
// Scoreboard bench for beam_trigger_aligner: a sample-timeline model pushes the expected
// trigger word every clock, a monitor pops and compares; directed checks use hand values.
module tb_beam_trigger_aligner;
  localparam int unsigned NB   = 46;
  localparam int unsigned GMAX = 8192;
  localparam int          TMAX = 262143;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [39:0]       din [7:0];
  logic [17:0]       thresh = '0;
  logic [NB-1:0]     ce = '0;
  logic              upd = 1'b0;
  logic [NB-1:0]     trig;

  int checks   = 0;
  int failures = 0;

  beam_trigger_aligner #(.NBEAMS(NB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (din),
    .thresh_i   (thresh),
    .thresh_ce_i(ce),
    .update_i   (upd),
    .trigger_o  (trig)
  );

  always #5 clk = ~clk;

  // Model state: samples by global index since reset, 4-deep power pipe, thresholds.
  int            xs [8][GMAX];
  int            gclk;
  int            ppipe [4][NB];
  int            pend_m [NB];
  int            act_m [NB];
  logic [NB-1:0] expq [$];

  function automatic int samp(logic [39:0] w, int s);
    logic signed [4:0] v;
    v = w[5*s +: 5];
    return int'(v);
  endfunction

  function automatic int model_power(int b, int n);
    int p;
    p = 0;
    for (int s = 0; s < 8; s++) begin
      int sb;
      sb = 0;
      for (int k = 0; k < 8; k++) begin
        int g;
        g = 8*n + s - ((b*k) % 16);
        if (g >= 0) sb += xs[k][g];
      end
      p += sb*sb;
    end
    return p;
  endfunction

  task automatic chk(string name, logic [NB-1:0] got, logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: on each clock push the expected trigger word registered at that edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      gclk = 0;
      expq.delete();
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < 4; i++) ppipe[i][b] = 0;
        pend_m[b] = TMAX;
        act_m[b]  = TMAX;
      end
    end else begin
      logic [NB-1:0] e;
      for (int b = 0; b < NB; b++) e[b] = (ppipe[3][b] > act_m[b]);
      expq.push_back(e);
      for (int i = 3; i > 0; i--) ppipe[i] = ppipe[i-1];
      if (8*gclk + 8 <= GMAX) begin
        for (int k = 0; k < 8; k++)
          for (int s = 0; s < 8; s++) xs[k][8*gclk+s] = samp(din[k], s);
        for (int b = 0; b < NB; b++) ppipe[0][b] = model_power(b, gclk);
        gclk++;
      end
      if (upd) for (int b = 0; b < NB; b++) act_m[b] = pend_m[b];
      for (int b = 0; b < NB; b++) if (ce[b]) pend_m[b] = int'(thresh);
    end
  end

  // Monitor: one result per clock, compared against the scoreboard.
  initial forever begin
    logic [NB-1:0] e;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trig_queue_empty t=%0t", $time);
      end else begin
        e = expq.pop_front();
        chk("trig_stream", trig, e);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_all(logic [4:0] v);
    for (int k = 0; k < 8; k++) din[k] = {8{v}};
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Load value into beams selected by mask, then pulse update.
  task automatic load_upd(logic [NB-1:0] mask, logic [17:0] v);
    @(negedge clk); ce = mask; thresh = v;
    @(negedge clk); ce = '0; upd = 1'b1;
    @(negedge clk); upd = 1'b0;
  endtask

  // Single impulse on channel k, sample s; beam 1 (threshold 0) must pulse only after edge pe.
  task automatic impulse(int k, int s, int pe);
    @(negedge clk);
    set_all(5'd0);
    din[k][5*s +: 5] = 5'd1;
    @(posedge clk);
    @(negedge clk);
    set_all(5'd0);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("impulse_k%0d_s%0d_edge%0d", k, s, i), NB'(trig[1]), NB'(i == pe));
    end
  endtask

  initial begin
    set_all(5'd0);
    // Reset default.
    @(negedge clk);
    chk("reset_trig", trig, '0);
    @(negedge clk);
    rst = 1'b0;
    set_all(5'd15);
    cyc(8);
    chk("reset_thresh_max_p115200", trig, '0);

    // Constant input: P = 512 per beam.
    load_upd('1, 18'd511);
    set_all(5'd1);
    cyc(8);
    chk("const1_above_511", trig, '1);
    load_upd('1, 18'd512);
    cyc(6);
    chk("const1_equal_512", trig, '0);

    // Selective load; nothing changes until update.
    @(negedge clk); ce = NB'(1); thresh = 18'd20;
    @(negedge clk); ce = NB'(2); thresh = 18'd10;
    @(negedge clk); ce = '0;
    cyc(3);
    chk("pending_not_active", trig, '0);
    upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    for (int k = 0; k < 8; k++)
      din[k] = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    cyc(8);
    chk("ramp_beam0_p8960", NB'(trig[0]), NB'(1));
    chk("ramp_beam1_p6272", NB'(trig[1]), NB'(1));
    chk("ramp_beam8_p8960", NB'(trig[8]), NB'(1));

    // Simultaneous ce and update: the new value waits for the next update.
    load_upd(NB'(1), 18'd100);
    set_all(5'd0);
    din[0] = {8{5'd1}};            // every beam sees P = 8
    @(negedge clk); ce = NB'(1); thresh = 18'd5; upd = 1'b1;
    @(negedge clk); ce = '0; upd = 1'b0;
    cyc(6);
    chk("simul_active_stays_100", NB'(trig[0]), NB'(0));
    upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    @(negedge clk);
    chk("second_update_active_5", NB'(trig[0]), NB'(1));

    // Delay alignment on beam 1.
    load_upd('1, 18'h3FFFF);
    load_upd(NB'(2), 18'd0);
    set_all(5'd0);
    cyc(5);
    impulse(3, 6, 5);              // g0+3 falls in the next clock
    impulse(7, 0, 4);              // g0+7 stays in the same clock
    impulse(0, 2, 4);

    // Reset mid-stream.
    load_upd('1, 18'd0);
    set_all(5'd1);
    cyc(6);
    chk("pre_reset_all_trig", trig, '1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clears", trig, '0);
    @(negedge clk);
    rst = 1'b0;
    cyc(8);
    chk("thresh_restored_after_reset", trig, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
